// File: rtl/beta_fetch_stage.sv
// ---------------------------------------------------------------------------
// beta_fetch_stage
//
// Instruction fetch stage of the Bourbon 3-stage pipeline. Holds the program
// counter, issues one instruction-memory request per fetch-enable pulse,
// presents the fetched instruction and its PC to the if-to-dec pipe register,
// and handles PC redirection, discarding responses that are already in flight.
//
// Optional feature macro: BETA_IFS_MISALIGN_CHECK_EN
//   defined   : fetches from a PC with pc[1:0] != 0 are refused and flagged
//               (sticky until the next jump or reset); jump targets kept as-is.
//   undefined : jump targets have bits [1:0] cleared; misaligned flag tied 0.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   ifs_fetch_en_i       fetch request pulse from the control unit
//   ifs_busy_o           high while a fetch is outstanding (state decode)
//   ifs_jump_i/_addr_i   PC redirect and its target
//   imem_req_o/_addr_o   instruction memory request and address
//   imem_gnt_i           request accepted
//   imem_rvalid_i/rdata_i response valid and data
//   ifs_instr_o/_pc_o    fetched instruction and its PC
//   ifs_valid_o          one-cycle pulse when a new instruction is presented
//   ifs_flush_i          squash the presented instruction
//   ifs_misaligned_o     misaligned-PC flag
// ---------------------------------------------------------------------------
module beta_fetch_stage #(
    parameter int unsigned                DataWidth = 32,
    parameter int unsigned                AddrWidth = 32,
    parameter logic [AddrWidth-1:0]       BootAddr  = '0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  ifs_fetch_en_i,
    output logic                  ifs_busy_o,
    input  logic                  ifs_jump_i,
    input  logic [AddrWidth-1:0]  ifs_jump_addr_i,
    output logic                  imem_req_o,
    output logic [AddrWidth-1:0]  imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DataWidth-1:0]  imem_rdata_i,
    output logic [DataWidth-1:0]  ifs_instr_o,
    output logic [AddrWidth-1:0]  ifs_pc_o,
    output logic                  ifs_valid_o,
    input  logic                  ifs_flush_i,
    output logic                  ifs_misaligned_o
);

    localparam logic [DataWidth-1:0] Nop = DataWidth'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] pc_q, pc_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 req_q, req_d;
    logic [DataWidth-1:0] instr_q, instr_d;
    logic [AddrWidth-1:0] pc_out_q, pc_out_d;
    logic                 valid_q, valid_d;
    logic                 drop_q, drop_d;
    logic                 mis_q, mis_d;

    logic [AddrWidth-1:0] jump_target;
    logic                 pc_misaligned;

`ifdef BETA_IFS_MISALIGN_CHECK_EN
    assign jump_target   = ifs_jump_addr_i;
    assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
    assign jump_target   = {ifs_jump_addr_i[AddrWidth-1:2], 2'b00};
    assign pc_misaligned = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            pc_q     <= BootAddr;
            addr_q   <= BootAddr;
            req_q    <= 1'b0;
            instr_q  <= Nop;
            pc_out_q <= BootAddr;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            mis_q    <= mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = 1'b0;
        drop_d   = drop_q;
        mis_d    = mis_q;

        // Any redirect clears the sticky misaligned flag.
        if (ifs_jump_i) mis_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ifs_jump_i) begin
                    pc_d = jump_target;
                end else if (ifs_fetch_en_i) begin
                    if (pc_misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        addr_d  = pc_q;
                    end
                end
            end
            S_REQ: begin
                if (imem_gnt_i) begin
                    state_d = S_WAIT;
                    // Request already accepted at the old address: its
                    // response must be thrown away.
                    if (ifs_jump_i) begin
                        pc_d   = jump_target;
                        drop_d = 1'b1;
                    end
                end else if (ifs_jump_i) begin
                    pc_d   = jump_target;
                    addr_d = jump_target;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (drop_q || ifs_jump_i) begin
                        // Stale response: re-issue at the (possibly new) PC
                        // without returning to IDLE, so busy never drops.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (ifs_jump_i) begin
                            pc_d   = jump_target;
                            addr_d = jump_target;
                        end else begin
                            addr_d = pc_q;
                        end
                    end else begin
                        state_d = S_IDLE;
                        pc_d    = pc_q + AddrWidth'(4);
                        if (!ifs_flush_i) begin
                            instr_d  = imem_rdata_i;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                        end
                    end
                end else if (ifs_jump_i) begin
                    pc_d   = jump_target;
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ifs_flush_i) begin
            instr_d = Nop;
            valid_d = 1'b0;
        end
    end

    assign req_d = (state_d == S_REQ);

    assign ifs_busy_o       = (state_q == S_REQ) || (state_q == S_WAIT);
    assign imem_req_o       = req_q;
    assign imem_addr_o      = addr_q;
    assign ifs_instr_o      = instr_q;
    assign ifs_pc_o         = pc_out_q;
    assign ifs_valid_o      = valid_q;
    assign ifs_misaligned_o = mis_q;

endmodule

// File: tb/tb_beta_fetch_stage.sv
module tb_beta_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_en;
    logic        busy;
    logic        jump;
    logic [31:0] jump_addr;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc_o;
    logic        valid;
    logic        flush;
    logic        misaligned;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Reference model: architectural PC the next fetch must use.
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    beta_fetch_stage #(
        .DataWidth(32),
        .AddrWidth(32),
        .BootAddr (32'h0000_0000)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .ifs_fetch_en_i  (fetch_en),
        .ifs_busy_o      (busy),
        .ifs_jump_i      (jump),
        .ifs_jump_addr_i (jump_addr),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_gnt_i      (gnt),
        .imem_rvalid_i   (rvalid),
        .imem_rdata_i    (rdata),
        .ifs_instr_o     (instr),
        .ifs_pc_o        (pc_o),
        .ifs_valid_o     (valid),
        .ifs_flush_i     (flush),
        .ifs_misaligned_o(misaligned)
    );

    // One complete fetch with gw grant-wait and rw response-wait cycles.
    task automatic do_fetch(input int unsigned gw, input int unsigned rw, input logic [31:0] data);
        @(negedge clk); fetch_en = 1'b1;
        @(negedge clk); fetch_en = 1'b0;
        checks++; if ({req, busy, addr} !== {1'b1, 1'b1, exp_pc}) $display("FAIL fetch_req got req=%b busy=%b addr=%h want 1 1 %h", req, busy, addr, exp_pc); else passes++;
        for (int unsigned i = 0; i < gw; i++) begin
            @(negedge clk);
            checks++; if ({req, busy, addr} !== {1'b1, 1'b1, exp_pc}) $display("FAIL gnt_wait_stable got req=%b busy=%b addr=%h want 1 1 %h", req, busy, addr, exp_pc); else passes++;
        end
        gnt = 1'b1;
        @(negedge clk); gnt = 1'b0;
        checks++; if ({req, busy} !== 2'b01) $display("FAIL after_gnt got req=%b busy=%b want 0 1", req, busy); else passes++;
        for (int unsigned i = 0; i < rw; i++) begin
            @(negedge clk);
            checks++; if ({busy, valid} !== 2'b10) $display("FAIL rvalid_wait got busy=%b valid=%b want 1 0", busy, valid); else passes++;
        end
        rvalid = 1'b1; rdata = data;
        @(negedge clk); rvalid = 1'b0;
        checks++; if ({valid, busy, instr, pc_o} !== {1'b1, 1'b0, data, exp_pc}) $display("FAIL response got valid=%b busy=%b instr=%h pc=%h want 1 0 %h %h", valid, busy, instr, pc_o, data, exp_pc); else passes++;
        @(negedge clk);
        checks++; if (valid !== 1'b0) $display("FAIL valid_pulse got %b want 0", valid); else passes++;
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_reset();
        rstn = 1'b0; fetch_en = 0; jump = 0; jump_addr = '0; gnt = 0; rvalid = 0; rdata = '0; flush = 0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, req, addr, instr, pc_o, valid, misaligned} !== {1'b0, 1'b0, 32'h0, NOP, 32'h0, 1'b0, 1'b0})
            $display("FAIL reset_state got busy=%b req=%b addr=%h instr=%h pc=%h valid=%b mis=%b", busy, req, addr, instr, pc_o, valid, misaligned); else passes++;
        rstn = 1'b1;
        exp_pc = 32'h0;
    endtask

    task automatic test_reset_then_fetch();
        do_fetch(0, 0, 32'h0050_0093);
        do_fetch(0, 0, 32'h1234_5678);   // must use 0x4
    endtask

    task automatic test_grant_wait();
        do_fetch(3, 0, 32'hA5A5_0001);
        do_fetch(1, 2, 32'hA5A5_0002);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    endtask

    task automatic test_jump_idle();
        logic [31:0] t;
        t = $urandom & 32'h0000_FFFC;
        @(negedge clk); jump = 1'b1; jump_addr = t;
        @(negedge clk); jump = 1'b0;
        checks++; if ({busy, req} !== 2'b00) $display("FAIL jump_idle_stays got busy=%b req=%b want 0 0", busy, req); else passes++;
        exp_pc = t;
        do_fetch(0, 1, $urandom);
    endtask

    task automatic test_jump_req();
        logic [31:0] d;
        d = $urandom;
        @(negedge clk); fetch_en = 1'b1;
        @(negedge clk); fetch_en = 1'b0; jump = 1'b1; jump_addr = 32'h300;
        @(negedge clk); jump = 1'b0;
        checks++; if ({req, addr} !== {1'b1, 32'h300}) $display("FAIL jump_req_addr got req=%b addr=%h want 1 300", req, addr); else passes++;
        gnt = 1'b1;
        @(negedge clk); gnt = 0; rvalid = 1'b1; rdata = d;
        @(negedge clk); rvalid = 0;
        checks++; if ({valid, pc_o, instr} !== {1'b1, 32'h300, d}) $display("FAIL jump_req_result got valid=%b pc=%h instr=%h want 1 300 %h", valid, pc_o, instr, d); else passes++;
        exp_pc = 32'h304;
    endtask

    task automatic test_jump_wait();
        logic [31:0] d;
        d = $urandom;
        @(negedge clk); fetch_en = 1'b1;
        @(negedge clk); fetch_en = 1'b0; gnt = 1'b1;
        @(negedge clk); gnt = 1'b0; jump = 1'b1; jump_addr = 32'h100;
        @(negedge clk); jump = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL jump_wait_busy got %b want 1", busy); else passes++;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk); rvalid = 1'b0;
        checks++; if ({valid, busy, req, addr} !== {1'b0, 1'b1, 1'b1, 32'h100}) $display("FAIL jump_wait_drop got valid=%b busy=%b req=%b addr=%h want 0 1 1 100", valid, busy, req, addr); else passes++;
        gnt = 1'b1;
        @(negedge clk); gnt = 0; rvalid = 1'b1; rdata = d;
        @(negedge clk); rvalid = 0;
        checks++; if ({valid, pc_o, instr} !== {1'b1, 32'h100, d}) $display("FAIL jump_wait_result got valid=%b pc=%h instr=%h want 1 100 %h", valid, pc_o, instr, d); else passes++;
        exp_pc = 32'h104;
    endtask

    task automatic test_jump_rvalid();
        logic [31:0] d;
        d = $urandom;
        @(negedge clk); fetch_en = 1'b1;
        @(negedge clk); fetch_en = 1'b0; gnt = 1'b1;
        @(negedge clk); gnt = 1'b0; jump = 1'b1; jump_addr = 32'h200; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        @(negedge clk); jump = 1'b0; rvalid = 1'b0;
        checks++; if ({valid, busy, req, addr} !== {1'b0, 1'b1, 1'b1, 32'h200}) $display("FAIL jump_rvalid_drop got valid=%b busy=%b req=%b addr=%h want 0 1 1 200", valid, busy, req, addr); else passes++;
        gnt = 1'b1;
        @(negedge clk); gnt = 0;
        checks++; if (busy !== 1'b1) $display("FAIL jump_rvalid_busy got %b want 1", busy); else passes++;
        rvalid = 1'b1; rdata = d;
        @(negedge clk); rvalid = 0;
        checks++; if ({valid, pc_o, instr} !== {1'b1, 32'h200, d}) $display("FAIL jump_rvalid_result got valid=%b pc=%h instr=%h want 1 200 %h", valid, pc_o, instr, d); else passes++;
        exp_pc = 32'h204;
    endtask

    task automatic test_flush_rvalid();
        @(negedge clk); fetch_en = 1'b1;
        @(negedge clk); fetch_en = 1'b0; gnt = 1'b1;
        @(negedge clk); gnt = 1'b0; rvalid = 1'b1; flush = 1'b1; rdata = 32'h0BAD_F00D;
        @(negedge clk); rvalid = 1'b0; flush = 1'b0;
        checks++; if ({instr, valid, busy} !== {NOP, 1'b0, 1'b0}) $display("FAIL flush_rvalid got instr=%h valid=%b busy=%b want %h 0 0", instr, valid, busy, NOP); else passes++;
        exp_pc = exp_pc + 32'd4;
        do_fetch(0, 0, $urandom);
    endtask

    task automatic test_wrap();
        @(negedge clk); jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
        @(negedge clk); jump = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        do_fetch(0, 0, $urandom);
        do_fetch(0, 0, $urandom);        // wrapped to 0x0
    endtask

    task automatic test_misaligned();
        @(negedge clk); jump = 1'b1; jump_addr = 32'h102;
        @(negedge clk); jump = 1'b0; fetch_en = 1'b1;
        @(negedge clk); fetch_en = 1'b0;
`ifdef BETA_IFS_MISALIGN_CHECK_EN
        checks++; if ({req, busy, misaligned} !== 3'b001) $display("FAIL misaligned_block got req=%b busy=%b mis=%b want 0 0 1", req, busy, misaligned); else passes++;
        @(negedge clk); jump = 1'b1; jump_addr = 32'h100;
        checks++; if (misaligned !== 1'b1) $display("FAIL misaligned_sticky got %b want 1", misaligned); else passes++;
        @(negedge clk); jump = 1'b0;
        checks++; if (misaligned !== 1'b0) $display("FAIL misaligned_clear got %b want 0", misaligned); else passes++;
        exp_pc = 32'h100;
        do_fetch(0, 0, $urandom);
`else
        checks++; if ({req, addr, misaligned} !== {1'b1, 32'h100, 1'b0}) $display("FAIL misaligned_align got req=%b addr=%h mis=%b want 1 100 0", req, addr, misaligned); else passes++;
        gnt = 1'b1;
        @(negedge clk); gnt = 0; rvalid = 1'b1; rdata = 32'h0000_0013;
        @(negedge clk); rvalid = 0;
        checks++; if ({valid, pc_o} !== {1'b1, 32'h100}) $display("FAIL misaligned_result got valid=%b pc=%h want 1 100", valid, pc_o); else passes++;
        exp_pc = 32'h104;
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk); fetch_en = 1'b1;
        @(negedge clk); fetch_en = 1'b0; gnt = 1'b1;
        @(negedge clk); gnt = 1'b0; rstn = 1'b0;
        #1;
        checks++; if ({busy, req, addr} !== {1'b0, 1'b0, 32'h0}) $display("FAIL reset_mid got busy=%b req=%b addr=%h want 0 0 0", busy, req, addr); else passes++;
        @(negedge clk); rstn = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_CAFE;
        @(negedge clk); rvalid = 1'b0;
        checks++; if ({valid, busy, instr, pc_o} !== {1'b0, 1'b0, NOP, 32'h0}) $display("FAIL late_rvalid got valid=%b busy=%b instr=%h pc=%h", valid, busy, instr, pc_o); else passes++;
        exp_pc = 32'h0;
        do_fetch(0, 0, $urandom);
    endtask

    initial begin
        test_reset();
        test_reset_then_fetch();
        test_grant_wait();
        test_random();
        test_jump_idle();
        test_jump_req();
        test_jump_wait();
        test_jump_rvalid();
        test_flush_rvalid();
        test_wrap();
        test_misaligned();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/beta_fetch_stage.md
# beta_fetch_stage

Instruction fetch stage of the Bourbon 3-stage pipeline. It holds the program counter and issues one instruction-memory request per fetch-enable pulse from the pipeline control unit. It presents the fetched instruction and its PC to the if-to-dec pipe register and reports `busy` back to the control unit. It also handles PC redirection (jump/branch) from the execution stage, including discarding in-flight responses.

## Interface

**Parameters**
- `DataWidth`, 32: instruction/data width.
- `AddrWidth`, 32: PC and imem address width.
- `BootAddr`, 32'h0000_0000: PC value after reset.

**Ports**
- `clk_i`, in, 1: clock.
- `rstn_i`, in, 1: reset. Asynchronous, active-low.
- `ifs_fetch_en_i`, in, 1: fetch request pulse from the control unit.
- `ifs_busy_o`, out, 1: high while a fetch is outstanding.
- `ifs_jump_i`, in, 1: redirect PC.
- `ifs_jump_addr_i`, in, AddrWidth: redirect target.
- `imem_req_o`, out, 1: memory request.
- `imem_addr_o`, out, AddrWidth: request address.
- `imem_gnt_i`, in, 1: request accepted.
- `imem_rvalid_i`, in, 1: response valid.
- `imem_rdata_i`, in, DataWidth: response data.
- `ifs_instr_o`, out, DataWidth: fetched instruction.
- `ifs_pc_o`, out, AddrWidth: PC of `ifs_instr_o`.
- `ifs_valid_o`, out, 1: one-cycle pulse when new instruction is presented.
- `ifs_flush_i`, in, 1: squash presented instruction.
- `ifs_misaligned_o`, out, 1: misaligned-PC flag (see Configuration).

## Operation

**Reset values**
- `pc = BootAddr`, state IDLE, `busy = 0`, `req = 0`, `addr = BootAddr`.
- `instr = 32'h0000_0013` (NOP), `ifs_pc_o = BootAddr`, `valid = 0`, `misaligned = 0`, drop flag 0.

**States**
- `ifs_busy_o` is high in REQ and WAIT, decoded from the state register.
- IDLE:
  - `fetch_en = 1` → REQ; `imem_addr_o <= pc`.
  - `fetch_en` is ignored in all other states.
- REQ:
  - `imem_req_o = 1`, address stable until `gnt`.
  - On `gnt` → WAIT.
- WAIT:
  - On `rvalid` with drop = 0: `instr <= rdata`, `ifs_pc_o <= pc`, `pc <= pc + 4` (wraps modulo 2^AddrWidth), `valid` pulses for 1 cycle, → IDLE.

**Jump**
- IDLE: `pc <= target`; stay IDLE.
- REQ, no `gnt`: `pc` and `addr <= target`; stay REQ.
- REQ with `gnt` same cycle: `pc <= target`, drop ← 1, → WAIT.
- WAIT: `pc <= target`, drop ← 1.
- WAIT with `rvalid` and drop = 1, or `rvalid` coinciding with a jump: response discarded, drop ← 0, no `valid` pulse, → REQ at `pc`. `busy` stays high throughout.

**Flush**
- `ifs_flush_i` sets `instr <= NOP` and `valid <= 0` next cycle. It does not alter the PC or the FSM.
- If flush and a good `rvalid` occur in the same cycle, flush wins: the instruction is dropped, `pc` still advances.

**Reset mid-operation**
- Any state returns immediately to IDLE with reset values. A late `rvalid` after reset is ignored because the state is IDLE.

## Timing

- `fetch_en` at cycle n → `imem_req_o` high at n+1.
- With `gnt` at n+1 and `rvalid` at n+2:
  - `ifs_instr_o`, `ifs_pc_o` and `ifs_valid_o` update at n+3.
  - `ifs_busy_o` falls at n+3.
- Minimum fetch-to-valid latency is 3 cycles. Each extra `gnt` or `rvalid` wait cycle adds one cycle.
- All outputs are registered except `ifs_busy_o` (state decode).
- At most one outstanding request.

## Configuration

Macro: `BETA_IFS_MISALIGN_CHECK_EN`.

**Defined**
- A fetch whose `pc[1:0] != 0` is not issued: on `fetch_en`, stay IDLE and set `ifs_misaligned_o`.
- `ifs_misaligned_o` is sticky until the next jump or reset.
- Jump targets are stored unmodified.

**Undefined**
- Jump targets are stored with bits [1:0] forced to 0.
- `ifs_misaligned_o` is tied 0.

## Test plan

- **Reset then fetch:** reset, `fetch_en` pulse; `gnt` immediate; `rvalid` next cycle with `rdata = 0x00500093`. Required: `imem_addr = 0x0`; `instr = 0x00500093`, `pc_o = 0x0` at n+3; `valid` for 1 cycle; next fetch uses `0x4`.
- **Grant wait:** hold `gnt` low 3 cycles. Required: `req` and `addr` stable for 4 cycles; `busy` high until the response.
- **Jump during WAIT:** jump to `0x100` while waiting. Required: old `rdata` discarded, no `valid`; new request at `0x100` without `fetch_en`; result `pc_o = 0x100`.
- **Jump and rvalid in the same cycle:** required: response dropped, REQ at target, `busy` never low.
- **Flush and rvalid in the same cycle:** required: `instr = NOP`, `valid = 0`, next fetch at `pc + 4`.
- **Misaligned jump:** jump to `0x102` then `fetch_en`.
  - With macro: no `req`, `misaligned = 1`.
  - Without macro: `addr = 0x100`.
